reg_access_arbiter: RTL and testbench
=====================================

Name: reg_access_arbiter

Overview:
- Parametrised N-channel front-end arbitrating register-bank accesses from multiple host peripherals (SPI, I2C, future UART/JTAG).
- Replaces the fixed select-line mux between host peripherals and reg_bank with round-robin arbitration, a per-channel request/ack handshake, address range checking and a bank-side timeout.
- Sits between host peripheral instances and reg_bank.

Parameters:
- NUM_CH, 2, number of requesting host channels (≥1)
- REG_W, 8, register data width
- ADDR_W, 8, channel address width
- NUM_REGS, 16, implemented registers; valid addresses 0..NUM_REGS-1
- BANK_ADDR_W, $clog2(NUM_REGS), bank address width
- TIMEOUT, 15, max BUSY cycles without bank_ack before error (≥1)
- CNT_W, 16, statistics counter width (optional feature only)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- ena  input  1  arbiter enable; low blocks new grants
- ch_req  input  NUM_CH  per-channel request, level
- ch_wr_rdn  input  NUM_CH  per-channel 1=write, 0=read
- ch_addr  input  NUM_CH*ADDR_W  packed addresses, channel 0 in LSBs
- ch_wdata  input  NUM_CH*REG_W  packed write data
- ch_ack  output  NUM_CH  one-cycle completion pulse to granted channel
- ch_err  output  NUM_CH  error flag, valid with ch_ack
- ch_rdata  output  REG_W  shared read data, valid with ch_ack
- bank_req  output  1  bank access request
- bank_wr_rdn  output  1  latched direction
- bank_addr  output  BANK_ADDR_W  latched address, truncated
- bank_wdata  output  REG_W  latched write data
- bank_ack  input  1  bank completion
- bank_rdata  input  REG_W  bank read data, valid with bank_ack

Behaviour:
- Reset values: all outputs 0, state IDLE, grant pointer 0, timeout counter 0.
- States: IDLE, BUSY, RESP. All outputs are decoded from registers.
- IDLE:
  - When ena=1 and any ch_req is high, select a channel round-robin, searching from the pointer upward with wrap.
  - Latch the channel index, wr_rdn, addr and wdata.
  - Set the pointer to granted+1, wrapping to 0 after NUM_CH-1.
- Range check in IDLE:
  - If the latched addr ≥ NUM_REGS, skip BUSY and go to RESP with err=1, rdata=0.
  - No bank_req is issued.
- Otherwise go to BUSY.
- BUSY:
  - bank_req=1 with the latched bank_* fields held stable.
  - On bank_ack=1: capture bank_rdata (reads; writes capture 0), err=0, go to RESP.
  - Else increment the counter.
  - When the counter reaches TIMEOUT-1 without ack: err=1, rdata=0, go to RESP.
  - bank_ack is ignored outside BUSY.
- RESP:
  - ch_ack[g]=1 for exactly one cycle, ch_err[g]=err, ch_rdata=captured data.
  - Clear the counter and go to IDLE.
  - ch_rdata holds its value until the next RESP.
- Latency: with a zero-wait bank (bank_ack in the first BUSY cycle), ch_ack rises 2 cycles after ch_req is sampled.
- Requester rule: deassert ch_req on the edge where ch_ack=1 is sampled. The arbiter samples requests only in IDLE.
- ena deasserted mid-transaction: the in-flight access completes normally; no new grant while ena=0.
- Simultaneous requests: exactly one grant per transaction, and a continuously requesting channel waits at most NUM_CH-1 transactions.
- NUM_CH=1: the pointer is constant 0.
- Reset asserted mid-transaction: immediate return to reset values. bank_req drops asynchronously and no ch_ack is generated.

Optional Feature:
- Macro: REG_ACCESS_ARBITER_STATS_EN.
- Defined: adds outputs stat_done (NUM_CH*CNT_W), per-channel completed-transaction counters, and stat_err (CNT_W), the total error count.
  - Both increment in RESP and saturate at all-ones.
  - Both reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single write: ch0 req, wr, addr 0x03, wdata 0xA5, bank_ack in the first BUSY cycle → bank_addr=3, bank_wdata=0xA5, ch_ack[0] 2 cycles after req, ch_err[0]=0.
- Read with wait states: ch1 read addr 0x0A, bank_ack after 3 cycles with rdata 0x5C → ch_rdata=0x5C with ch_ack[1], ch_err=0.
- Round-robin: ch0 and ch1 request continuously from reset → grants in order 0,1,0,1; no channel granted twice consecutively.
- Out of range: ch0 read addr 0x10 with NUM_REGS=16 → bank_req never asserted, ch_ack[0] with ch_err[0]=1, ch_rdata=0x00.
- Timeout: bank_ack held 0, TIMEOUT=15 → bank_req high for 15 cycles, then ch_ack with ch_err=1; with STATS_EN, stat_err=1.
- Reset mid-BUSY: assert rst during BUSY → bank_req and all outputs 0 immediately; after release, the next ch0 request is granted first.

Source files
------------

// File: rtl/reg_access_arbiter.sv
// Round-robin N-channel register-bank arbiter with range check and bank timeout; zero-wait access acks 2 cycles after request.
// Backpressure: one transaction in flight, requests sampled only in IDLE; REG_ACCESS_ARBITER_STATS_EN adds completion/error counters.
module reg_access_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int REG_W       = 8,
    parameter int ADDR_W      = 8,
    parameter int NUM_REGS    = 16,
    parameter int BANK_ADDR_W = $clog2(NUM_REGS),
    parameter int TIMEOUT     = 15,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_wr_rdn,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*REG_W-1:0]  ch_wdata,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [REG_W-1:0]         ch_rdata,
    output logic                     bank_req,
    output logic                     bank_wr_rdn,
    output logic [BANK_ADDR_W-1:0]   bank_addr,
    output logic [REG_W-1:0]         bank_wdata,
    input  logic                     bank_ack,
    input  logic [REG_W-1:0]         bank_rdata
`ifdef REG_ACCESS_ARBITER_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]  stat_done,
    output logic [CNT_W-1:0]         stat_err
`endif
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    state_t                 state_q, state_d;
    logic [CH_W-1:0]        grant_q, grant_d;
    logic [CH_W-1:0]        ptr_q, ptr_d;
    logic [TO_W-1:0]        cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [REG_W-1:0]       rdata_q, rdata_d;
    logic                   wr_q, wr_d;
    logic [BANK_ADDR_W-1:0] addr_q, addr_d;
    logic [REG_W-1:0]       wdata_q, wdata_d;

    logic                   found;
    logic [CH_W-1:0]        sel;
    logic [ADDR_W-1:0]      sel_addr;
    logic                   sel_oor;

    // Round-robin search from the pointer upward, wrapping at NUM_CH.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(ptr_q) + i) % NUM_CH;
            if (!found && ch_req[idx]) begin
                found = 1'b1;
                sel   = CH_W'(idx);
            end
        end
        sel_addr = ch_addr[int'(sel)*ADDR_W +: ADDR_W];
        sel_oor  = 32'(sel_addr) >= 32'(NUM_REGS);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (ena && found) begin
                    grant_d = sel;
                    ptr_d   = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
                    wr_d    = ch_wr_rdn[sel];
                    addr_d  = sel_addr[BANK_ADDR_W-1:0];
                    wdata_d = ch_wdata[int'(sel)*REG_W +: REG_W];
                    cnt_d   = '0;
                    if (sel_oor) begin
                        // Unimplemented address: answer with an error without touching the bank.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (bank_ack) begin
                    err_d   = 1'b0;
                    rdata_d = wr_q ? '0 : bank_rdata;
                    state_d = ST_RESP;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ack[i] = (state_q == ST_RESP) && (grant_q == CH_W'(i));
            ch_err[i] = (state_q == ST_RESP) && (grant_q == CH_W'(i)) && err_q;
        end
    end

    assign ch_rdata    = rdata_q;
    assign bank_req    = (state_q == ST_BUSY);
    assign bank_wr_rdn = wr_q;
    assign bank_addr   = addr_q;
    assign bank_wdata  = wdata_q;

`ifdef REG_ACCESS_ARBITER_STATS_EN
    logic [NUM_CH*CNT_W-1:0] stat_done_q, stat_done_d;
    logic [CNT_W-1:0]        stat_err_q, stat_err_d;

    // Saturating counters, bumped once per response cycle.
    always_comb begin
        stat_done_d = stat_done_q;
        stat_err_d  = stat_err_q;
        if (state_q == ST_RESP) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant_q == CH_W'(i) && stat_done_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
                    stat_done_d[i*CNT_W +: CNT_W] = stat_done_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
            if (err_q && stat_err_q != {CNT_W{1'b1}}) begin
                stat_err_d = stat_err_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_done_q <= '0;
            stat_err_q  <= '0;
        end else begin
            stat_done_q <= stat_done_d;
            stat_err_q  <= stat_err_d;
        end
    end

    assign stat_done = stat_done_q;
    assign stat_err  = stat_err_q;
`endif

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed plus randomized bench for reg_access_arbiter against a transaction-level reference model.
module tb_reg_access_arbiter;

    localparam int NUM_CH   = 2;
    localparam int REG_W    = 8;
    localparam int ADDR_W   = 8;
    localparam int NUM_REGS = 16;
    localparam int BAW      = 4;
    localparam int TIMEOUT  = 15;
    localparam int CNT_W    = 16;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     ena = 1'b0;
    logic [NUM_CH-1:0]        ch_req = '0;
    logic [NUM_CH-1:0]        ch_wr_rdn;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*REG_W-1:0]  ch_wdata;
    logic [NUM_CH-1:0]        ch_ack;
    logic [NUM_CH-1:0]        ch_err;
    logic [REG_W-1:0]         ch_rdata;
    logic                     bank_req;
    logic                     bank_wr_rdn;
    logic [BAW-1:0]           bank_addr;
    logic [REG_W-1:0]         bank_wdata;
    logic                     bank_ack = 1'b0;
    logic [REG_W-1:0]         bank_rdata = '0;
`ifdef REG_ACCESS_ARBITER_STATS_EN
    logic [NUM_CH*CNT_W-1:0]  stat_done;
    logic [CNT_W-1:0]         stat_err;
`endif

    // Per-channel requester intent.
    logic              m_wr[NUM_CH];
    logic [ADDR_W-1:0] m_addr[NUM_CH];
    logic [REG_W-1:0]  m_wdata[NUM_CH];

    // Reference model state.
    int m_ptr = 0;
    int m_done[NUM_CH];
    int m_errs = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_wr_rdn[c]                 = m_wr[c];
            ch_addr[c*ADDR_W +: ADDR_W]  = m_addr[c];
            ch_wdata[c*REG_W +: REG_W]   = m_wdata[c];
        end
    end

    reg_access_arbiter #(
        .NUM_CH(NUM_CH), .REG_W(REG_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
        .BANK_ADDR_W(BAW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .ch_req(ch_req), .ch_wr_rdn(ch_wr_rdn), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_ack(ch_ack), .ch_err(ch_err), .ch_rdata(ch_rdata),
        .bank_req(bank_req), .bank_wr_rdn(bank_wr_rdn), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_ack(bank_ack), .bank_rdata(bank_rdata)
`ifdef REG_ACCESS_ARBITER_STATS_EN
        , .stat_done(stat_done), .stat_err(stat_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        m_wr[c]    = wr;
        m_addr[c]  = addr;
        m_wdata[c] = wdata;
    endtask

    // One arbitrated transaction, entered and left at a falling edge with the arbiter idle.
    // lat < 0 means the bank never acknowledges; otherwise ack arrives in BUSY cycle lat+1.
    task automatic do_txn(input logic [NUM_CH-1:0] mask, input int lat, input logic [7:0] bdata,
                          input bit noise, output int cyc);
        int  g;
        int  busy;
        bit  got;
        bit  oor;
        bit  tmo;
        int  exp_busy;
        logic [7:0] exp_rd;
        ena    = 1'b1;
        ch_req = mask;
        g = -1;
        for (int i = 0; i < NUM_CH; i++) begin
            int c;
            c = (m_ptr + i) % NUM_CH;
            if (g < 0 && mask[c]) g = c;
        end
        m_ptr = (g + 1) % NUM_CH;
        oor   = int'(m_addr[g]) >= NUM_REGS;
        busy  = 0;
        cyc   = 0;
        got   = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            cyc++;
            if (ch_ack != '0) begin
                got = 1'b1;
            end else if (bank_req) begin
                busy++;
                check("bank_addr", 32'(bank_addr), 32'(m_addr[g][3:0]));
                check("bank_wdata", 32'(bank_wdata), 32'(m_wdata[g]));
                check("bank_wr_rdn", 32'(bank_wr_rdn), 32'(m_wr[g]));
                bank_ack   = (lat >= 0) && (busy == lat + 1);
                bank_rdata = bank_ack ? bdata : 8'($urandom);
                if (noise) ena = 1'($urandom);
            end else begin
                bank_ack   = noise ? 1'($urandom) : 1'b0;
                bank_rdata = 8'($urandom);
            end
        end
        bank_ack = 1'b0;
        ena      = 1'b1;
        if (!got) begin
            failures++;
            $error("FAIL ack_wait observed=none expected=ch_ack within 60 cycles");
            ch_req = '0;
            return;
        end
        tmo      = !oor && lat < 0;
        exp_busy = oor ? 0 : (tmo ? TIMEOUT : lat + 1);
        exp_rd   = (oor || tmo || m_wr[g]) ? 8'h00 : bdata;
        check("ch_ack", 32'(ch_ack), 32'(1) << g);
        check("ch_err", 32'(ch_err), (oor || tmo) ? (32'(1) << g) : 32'(0));
        check("ch_rdata", 32'(ch_rdata), 32'(exp_rd));
        check("busy_cycles", 32'(busy), 32'(exp_busy));
        m_done[g]++;
        if (oor || tmo) m_errs++;
        ch_req[g] = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 32'(ch_ack), 32'(0));
        check("rdata_hold", 32'(ch_rdata), 32'(exp_rd));
    endtask

    initial begin
        int cyc;
        int lat;
        for (int c = 0; c < NUM_CH; c++) begin
            set_ch(c, 1'b0, 8'h00, 8'h00);
            m_done[c] = 0;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_bank_req", 32'(bank_req), 0);
        check("rst_ch_ack", 32'(ch_ack), 0);
        check("rst_ch_err", 32'(ch_err), 0);
        check("rst_ch_rdata", 32'(ch_rdata), 0);
        check("rst_bank_addr", 32'(bank_addr), 0);
        check("rst_bank_wdata", 32'(bank_wdata), 0);
        check("rst_bank_wr", 32'(bank_wr_rdn), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single zero-wait write on ch0
        set_ch(0, 1'b1, 8'h03, 8'hA5);
        do_txn(2'b01, 0, 8'h77, 1'b0, cyc);
        check("write_latency", 32'(cyc), 2);

        // Read with wait states on ch1
        set_ch(1, 1'b0, 8'h0A, 8'h00);
        do_txn(2'b10, 3, 8'h5C, 1'b0, cyc);

        // Round-robin with both channels requesting continuously: 0,1,0,1
        set_ch(0, 1'b0, 8'h01, 8'h11);
        set_ch(1, 1'b1, 8'h0F, 8'h22);
        for (int t = 0; t < 4; t++) do_txn(2'b11, t % 2, 8'h40 + 8'(t), 1'b0, cyc);

        // Out-of-range read on ch0
        set_ch(0, 1'b0, 8'h10, 8'h00);
        do_txn(2'b01, 0, 8'hEE, 1'b0, cyc);

        // Bank timeout on ch1
        set_ch(1, 1'b0, 8'h05, 8'h00);
        do_txn(2'b10, -1, 8'hEE, 1'b0, cyc);
`ifdef REG_ACCESS_ARBITER_STATS_EN
        check("stat_err_mid", 32'(stat_err), 32'(m_errs));
`endif

        // ena low blocks new grants
        set_ch(0, 1'b0, 8'h02, 8'h00);
        ena    = 1'b0;
        ch_req = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("ena_low_bank_req", 32'(bank_req), 0);
            check("ena_low_ch_ack", 32'(ch_ack), 0);
        end
        do_txn(2'b01, 1, 8'h9B, 1'b0, cyc);

        // Reset during BUSY of ch1 (pointer currently at 1)
        ch_req = 2'b11;
        @(negedge clk);
        check("pre_rst_bank_req", 32'(bank_req), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_bank_req", 32'(bank_req), 0);
        check("rst_mid_ch_ack", 32'(ch_ack), 0);
        check("rst_mid_ch_rdata", 32'(ch_rdata), 0);
        check("rst_mid_bank_addr", 32'(bank_addr), 0);
        ch_req = '0;
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        m_errs = 0;
        for (int c = 0; c < NUM_CH; c++) m_done[c] = 0;
        @(negedge clk);
        set_ch(0, 1'b1, 8'h07, 8'h3C);
        set_ch(1, 1'b1, 8'h08, 8'hC3);
        do_txn(2'b11, 0, 8'h00, 1'b0, cyc);

        // Randomized traffic with ena drops and stray bank_ack outside BUSY
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NUM_CH; c++)
                set_ch(c, 1'($urandom), 8'($urandom_range(0, 19)), 8'($urandom));
            lat = $urandom_range(0, 9);
            if (lat > 4) lat = (lat == 9) ? -1 : lat - 5;
            do_txn(NUM_CH'($urandom_range(1, 3)), lat, 8'($urandom), 1'b1, cyc);
        end
        ch_req = '0;

`ifdef REG_ACCESS_ARBITER_STATS_EN
        for (int c = 0; c < NUM_CH; c++)
            check("stat_done", 32'(stat_done[c*CNT_W +: CNT_W]), 32'(m_done[c]));
        check("stat_err", 32'(stat_err), 32'(m_errs));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
